// File: rtl/seg7_scan_driver.sv
// Binary to BCD converter (serial shift-and-add-3) with a multiplexed 7-segment scan driver.
// Optional leading-zero blanking is enabled by defining SEG7_LEAD_ZERO_BLANK_EN.
module seg7_scan_driver #(
  parameter int BIN_W    = 14,
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 50000
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic [BIN_W-1:0]  BinIn,
  input  logic              Load,
  output logic              Busy,
  output logic              Done,
  output logic              Overflow,
  output logic [7:0]        SegOut,
  output logic [DIGITS-1:0] DigSel
);

  localparam int ACC_D = (BIN_W + 2) / 3 + 1;
  localparam int ACC_W = 4 * ACC_D;
  localparam int EXT_W = ((ACC_W + 1) > (4 * DIGITS + 1)) ? (ACC_W + 1) : (4 * DIGITS + 1);
  localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BIT_W = $clog2(BIN_W + 1);

  typedef enum logic {
    S_IDLE,
    S_CONV
  } state_t;

  state_t              r_state;
  logic [BIN_W-1:0]    r_shift;
  logic [ACC_W-1:0]    r_acc;
  logic [BIT_W-1:0]    r_bitCnt;
  logic                r_busy;
  logic                r_done;
  logic                r_ovf;
  logic [4*DIGITS-1:0] r_disp;
  logic [CNT_W-1:0]    r_scanCnt;
  logic [DIGITS-1:0]   r_digSel;

  logic [ACC_W-1:0]    w_adj;
  logic [ACC_W:0]      w_accNext;
  logic [EXT_W-1:0]    w_ext;
  logic                w_ovfNext;
  logic [DIGITS-1:0]   w_lead;
  logic                w_zeroAbove;
  logic [3:0]          w_nibble;
  logic                w_blank;
  logic [7:0]          w_seg;

  // Add-3 correction on every nibble that would otherwise exceed 9 after the shift.
  always_comb begin
    w_adj = r_acc;
    for (int d = 0; d < ACC_D; d++) begin
      if (r_acc[4*d +: 4] >= 4'd5) begin
        w_adj[4*d +: 4] = r_acc[4*d +: 4] + 4'd3;
      end
    end
  end

  assign w_accNext = {w_adj, r_shift[BIN_W-1]};

  always_comb begin
    w_ext     = EXT_W'(w_accNext);
    w_ovfNext = |w_ext[EXT_W-1:4*DIGITS];
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_state  <= S_IDLE;
      r_shift  <= '0;
      r_acc    <= '0;
      r_bitCnt <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_ovf    <= 1'b0;
      r_disp   <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (Load) begin
            r_shift  <= BinIn;
            r_acc    <= '0;
            r_bitCnt <= '0;
            r_busy   <= 1'b1;
            r_state  <= S_CONV;
          end
        end
        S_CONV: begin
          r_acc    <= w_accNext[ACC_W-1:0];
          r_shift  <= {r_shift[BIN_W-2:0], 1'b0};
          r_bitCnt <= r_bitCnt + BIT_W'(1);
          // The last shift lands straight in the display so Done and the new digits coincide.
          if (r_bitCnt == BIT_W'(BIN_W - 1)) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_disp  <= w_ext[4*DIGITS-1:0];
            r_ovf   <= w_ovfNext;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      r_scanCnt <= '0;
      r_digSel  <= DIGITS'(1);
    end else if (r_scanCnt == CNT_W'(SCAN_DIV - 1)) begin
      r_scanCnt <= '0;
      r_digSel  <= (r_digSel << 1) | (r_digSel >> (DIGITS - 1));
    end else begin
      r_scanCnt <= r_scanCnt + CNT_W'(1);
    end
  end

`ifdef SEG7_LEAD_ZERO_BLANK_EN
  // A digit is blank when it and every digit above it are zero; the units digit always shows.
  always_comb begin
    w_lead      = '0;
    w_zeroAbove = 1'b1;
    for (int d = DIGITS - 1; d >= 1; d--) begin
      w_lead[d]   = w_zeroAbove && (r_disp[4*d +: 4] == 4'd0);
      w_zeroAbove = w_lead[d];
    end
  end
`else
  always_comb begin
    w_lead      = '0;
    w_zeroAbove = 1'b0;
  end
`endif

  always_comb begin
    w_nibble = 4'd0;
    w_blank  = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (r_digSel[i]) begin
        w_nibble = r_disp[4*i +: 4];
        w_blank  = w_lead[i];
      end
    end
  end

  always_comb begin
    case (w_nibble)
      4'd0:    w_seg = 8'b11111100;
      4'd1:    w_seg = 8'b01100000;
      4'd2:    w_seg = 8'b11011010;
      4'd3:    w_seg = 8'b11110010;
      4'd4:    w_seg = 8'b01100110;
      4'd5:    w_seg = 8'b10110110;
      4'd6:    w_seg = 8'b10111110;
      4'd7:    w_seg = 8'b11100000;
      4'd8:    w_seg = 8'b11111110;
      4'd9:    w_seg = 8'b11110110;
      default: w_seg = 8'b00000000;
    endcase
  end

  // SegOut is decoded from the same registers that drive DigSel, so the two never disagree.
  always_comb begin
    if (r_ovf) begin
      SegOut = 8'b00000010;
    end else if (w_blank) begin
      SegOut = 8'b00000000;
    end else begin
      SegOut = w_seg;
    end
  end

  assign Busy     = r_busy;
  assign Done     = r_done;
  assign Overflow = r_ovf;
  assign DigSel   = r_digSel;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Self-checking bench for seg7_scan_driver: table of conversions, scoreboarded display checks,
// plus hand-written reset, abort and Load-handling sequences.
`timescale 1ns/1ps
module tb_seg7_scan_driver;

  localparam int BIN_W    = 14;
  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 4;

  logic             Clk;
  logic             Rst;
  logic [BIN_W-1:0] BinIn;
  logic             Load;
  logic             Busy;
  logic             Done;
  logic             Overflow;
  logic [7:0]       SegOut;
  logic [DIGITS-1:0] DigSel;

  typedef struct packed {
    logic [BIN_W-1:0] bin;
    logic             ovf;
    logic [3:0][7:0]  seg;
  } vec_t;

  typedef struct packed {
    logic            ovf;
    logic [3:0][7:0] seg;
  } exp_t;

  vec_t vecs [8];
  exp_t sbQ [$];
  exp_t curExp;
  int   checks = 0;
  int   errors = 0;

  seg7_scan_driver #(
    .BIN_W(BIN_W),
    .DIGITS(DIGITS),
    .SCAN_DIV(SCAN_DIV)
  ) dut (
    .Clk(Clk),
    .Rst(Rst),
    .BinIn(BinIn),
    .Load(Load),
    .Busy(Busy),
    .Done(Done),
    .Overflow(Overflow),
    .SegOut(SegOut),
    .DigSel(DigSel)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #200us;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog");
  end

  function automatic vec_t mkVec(input logic [BIN_W-1:0] bin, input logic ovf,
                                 input logic [7:0] s3, input logic [7:0] s2,
                                 input logic [7:0] s1, input logic [7:0] s0);
    vec_t v;
    v.bin = bin;
    v.ovf = ovf;
    v.seg = {s3, s2, s1, s0};
    return v;
  endfunction

  // Turns the unblanked table entry into what the display should show in this build.
  function automatic exp_t expOf(input vec_t v);
    exp_t e;
    logic zeroRun;
    e.ovf = v.ovf;
    e.seg = v.seg;
    zeroRun = 1'b1;
`ifdef SEG7_LEAD_ZERO_BLANK_EN
    if (!v.ovf) begin
      for (int d = 3; d >= 1; d--) begin
        if (zeroRun && v.seg[d] == 8'b11111100) e.seg[d] = 8'b00000000;
        else zeroRun = 1'b0;
      end
    end
`endif
    return e;
  endfunction

  function automatic int selIdx(input logic [3:0] s);
    for (int i = 0; i < 4; i++) if (s[i]) return i;
    return 0;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    sbQ.push_back(expOf(v));
    Load  = 1'b1;
    BinIn = v.bin;
    @(posedge Clk); #1;
    Load  = 1'b0;
  endtask

  // Called one cycle after the capturing edge; returns after the cycle following Done.
  task automatic waitConversion(input int injectAt, input bit chain, input vec_t chainVec);
    int busyCnt;
    busyCnt = 0;
    while (Busy === 1'b1 && busyCnt < 100) begin
      busyCnt++;
      if (busyCnt == injectAt) begin
        Load  = 1'b1;
        BinIn = 14'd5;
      end else begin
        Load = 1'b0;
      end
      @(posedge Clk); #1;
    end
    Load = 1'b0;
    checkOutput("busy_cycles", busyCnt, BIN_W);
    checkOutput("done_pulse", Done, 1);
    if (sbQ.size() == 0) begin
      checkOutput("scoreboard_empty", 0, 1);
    end else begin
      curExp = sbQ.pop_front();
    end
    checkOutput("overflow", Overflow, curExp.ovf);
    checkOutput("seg_done_cycle", SegOut, curExp.seg[selIdx(DigSel)]);
    if (chain) applyStimulus(chainVec);
    else begin
      @(posedge Clk); #1;
    end
    checkOutput("done_one_cycle", Done, 0);
  endtask

  task automatic scanDisplay();
    for (int c = 0; c < 4 * SCAN_DIV; c++) begin
      checkOutput("digsel_onehot", $onehot(DigSel), 1);
      checkOutput("seg_scan", SegOut, curExp.seg[selIdx(DigSel)]);
      @(posedge Clk); #1;
    end
  endtask

  vec_t v42, v5, v777, vZero, vNone;
  int   doneSeen;

  initial begin
    vecs[0] = mkVec(14'd1234,  1'b0, 8'h60, 8'hDA, 8'hF2, 8'h66);
    vecs[1] = mkVec(14'd9999,  1'b0, 8'hF6, 8'hF6, 8'hF6, 8'hF6);
    vecs[2] = mkVec(14'd10000, 1'b1, 8'h02, 8'h02, 8'h02, 8'h02);
    vecs[3] = mkVec(14'd16383, 1'b1, 8'h02, 8'h02, 8'h02, 8'h02);
    vecs[4] = mkVec(14'd0,     1'b0, 8'hFC, 8'hFC, 8'hFC, 8'hFC);
    vecs[5] = mkVec(14'd7,     1'b0, 8'hFC, 8'hFC, 8'hFC, 8'hE0);
    vecs[6] = mkVec(14'd2468,  1'b0, 8'hDA, 8'h66, 8'hBE, 8'hFE);
    vecs[7] = mkVec(14'd5050,  1'b0, 8'hB6, 8'hFC, 8'hB6, 8'hFC);
    v42   = mkVec(14'd42,  1'b0, 8'hFC, 8'hFC, 8'h66, 8'hDA);
    v5    = mkVec(14'd5,   1'b0, 8'hFC, 8'hFC, 8'hFC, 8'hB6);
    v777  = mkVec(14'd777, 1'b0, 8'hFC, 8'hE0, 8'hE0, 8'hE0);
    vZero = mkVec(14'd0,   1'b0, 8'hFC, 8'hFC, 8'hFC, 8'hFC);
    vNone = vZero;

    Rst = 1'b1; Load = 1'b0; BinIn = '0;
    repeat (2) @(posedge Clk);
    #1 Rst = 1'b0;
    repeat (6) @(posedge Clk);
    #1;

    // Reset in the middle of a scan period, then watch the first digit rotation.
    Rst = 1'b1;
    @(posedge Clk); #1;
    Rst = 1'b0;
    checkOutput("rst_busy", Busy, 0);
    checkOutput("rst_done", Done, 0);
    checkOutput("rst_overflow", Overflow, 0);
    checkOutput("rst_digsel", DigSel, 4'b0001);
    checkOutput("rst_segout", SegOut, 8'b11111100);
    repeat (3) @(posedge Clk);
    #1 checkOutput("rst_digsel_hold", DigSel, 4'b0001);
    @(posedge Clk); #1;
    checkOutput("rst_digsel_rotate", DigSel, 4'b0010);

    // Reset during cycle 7 of a conversion must leave no trace on the display.
    applyStimulus(v777);
    repeat (6) @(posedge Clk);
    #1 Rst = 1'b1;
    #2 checkOutput("abort_busy_async", Busy, 0);
    @(posedge Clk); #1;
    Rst = 1'b0;
    sbQ.delete();
    doneSeen = 0;
    for (int c = 0; c < 20; c++) begin
      if (Done === 1'b1) doneSeen++;
      @(posedge Clk); #1;
    end
    checkOutput("abort_no_done", doneSeen, 0);
    checkOutput("abort_busy", Busy, 0);
    checkOutput("abort_overflow", Overflow, 0);
    curExp = expOf(vZero);
    scanDisplay();

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i]);
      waitConversion(0, 1'b0, vNone);
      scanDisplay();
    end

    // Load during cycle 3 of a conversion is ignored.
    applyStimulus(v42);
    waitConversion(3, 1'b0, vNone);
    scanDisplay();

    // Load in the Done cycle is accepted.
    applyStimulus(v42);
    waitConversion(0, 1'b1, v5);
    waitConversion(0, 1'b0, vNone);
    scanDisplay();

    checkOutput("scoreboard_drained", sbQ.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
